// File: rtl/queue_sched_pkg.sv
// Shared sizing defaults and FSM state encoding for the queue scheduler.
package queue_sched_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ENQ,
        DEQ,
        CAPTURE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a single last-grant flop and one-hot grant.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // last resets to 1 so the very first contention goes to requester 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (grant[0]) begin
            last <= 1'b0;
        end else if (grant[1]) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/queue_sched.sv
// Schedules deserializer writes and consumer reads onto a single-port queue,
// one queue operation per cycle, round-robin when both sides are ready.
module queue_sched #(
    parameter int DATA_W = queue_sched_pkg::DATA_W,
    parameter int DEPTH  = queue_sched_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ack_out,
    input  logic              rd_req_in,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_valid_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              q_enq_out,
    output logic [DATA_W-1:0] q_data_out,
    output logic              q_deq_out,
    input  logic [DATA_W-1:0] q_data_in,
    input  logic [7:0]        q_len_in
);

    import queue_sched_pkg::*;

    state_t     state;
    state_t     next_state;
    logic       rd_pending;
    logic       in_idle;
    logic [1:0] req;
    logic [1:0] grant;

    // Occupancy beyond DEPTH is treated as full
    assign full_out  = (q_len_in >= 8'(DEPTH));
    assign empty_out = (q_len_in == 8'd0);
    assign in_idle   = (state == IDLE);

    // Requester 0 is the write side, requester 1 the read side
    assign req = {rd_pending && !empty_out, wr_valid_in && !full_out};

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (in_idle),
        .req    (req),
        .grant  (grant)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant[0]) begin
                    next_state = ENQ;
                end else if (grant[1]) begin
                    next_state = DEQ;
                end
            end
            ENQ:     next_state = IDLE;
            DEQ:     next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wr_ack_out = 1'b0;
        q_enq_out  = 1'b0;
        q_deq_out  = 1'b0;
        case (state)
            ENQ: begin
                wr_ack_out = 1'b1;
                q_enq_out  = 1'b1;
            end
            DEQ:     q_deq_out = 1'b1;
            default: ;
        endcase
    end

    // The write word is captured on grant so the queue sees it for the whole
    // ENQ cycle and it stays put afterwards; a read request stays pending
    // until its word has been captured, and extra pulses in between are lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_data_out   <= '0;
            rd_data_out  <= '0;
            rd_valid_out <= 1'b0;
            rd_pending   <= 1'b0;
        end else begin
            rd_valid_out <= 1'b0;
            if (in_idle && grant[0]) begin
                q_data_out <= wr_data_in;
            end
            if (state == CAPTURE) begin
                rd_data_out  <= q_data_in;
                rd_valid_out <= 1'b1;
                rd_pending   <= 1'b0;
            end else if (rd_req_in) begin
                rd_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_queue_sched.sv
// Scoreboard bench for queue_sched: a behavioural queue sits on the q_* ports,
// directed stimulus pushes expected words, a monitor pops and compares them.
`timescale 1us/1ns
module tb_queue_sched;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid_in = 1'b0;
    logic [7:0] wr_data_in = 8'h00;
    logic       wr_ack_out;
    logic       rd_req_in = 1'b0;
    logic [7:0] rd_data_out;
    logic       rd_valid_out;
    logic       full_out;
    logic       empty_out;
    logic       q_enq_out;
    logic [7:0] q_data_out;
    logic       q_deq_out;
    logic [7:0] q_data_in = 8'h00;
    logic [7:0] q_len_in = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] qmem[$];

    queue_sched dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid_in  (wr_valid_in),
        .wr_data_in   (wr_data_in),
        .wr_ack_out   (wr_ack_out),
        .rd_req_in    (rd_req_in),
        .rd_data_out  (rd_data_out),
        .rd_valid_out (rd_valid_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .q_enq_out    (q_enq_out),
        .q_data_out   (q_data_out),
        .q_deq_out    (q_deq_out),
        .q_data_in    (q_data_in),
        .q_len_in     (q_len_in)
    );

    always #50 clock = ~clock;

    // Behavioural queue: output word is valid the cycle after a dequeue
    always @(posedge clock) begin
        if (q_enq_out) begin
            qmem.push_back(q_data_out);
        end
        if (q_deq_out && qmem.size() > 0) begin
            q_data_in <= qmem.pop_front();
        end
        q_len_in <= 8'(qmem.size());
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic monitorLoop();
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (wr_ack_out) begin
                checkOutput("enq_with_ack", 32'(q_enq_out), 32'd1);
                if (exp_wr.size() == 0) begin
                    checkOutput("wr_ack_unexpected", 32'(wr_ack_out), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    checkOutput("q_data_out", 32'(q_data_out), 32'(e));
                end
            end
            if (rd_valid_out) begin
                if (exp_rd.size() == 0) begin
                    checkOutput("rd_valid_unexpected", 32'(rd_valid_out), 32'd0);
                end else begin
                    e = exp_rd.pop_front();
                    checkOutput("rd_data_out", 32'(rd_data_out), 32'(e));
                end
            end
        end
    endtask

    task automatic do_write(input logic [7:0] d, output int lat);
        wr_data_in  = d;
        wr_valid_in = 1'b1;
        exp_wr.push_back(d);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (wr_ack_out) begin
                lat = i;
                break;
            end
        end
        wr_valid_in = 1'b0;
        if (lat < 0) begin
            checkOutput("wr_ack_timeout", 32'(lat), 32'd1);
        end
        @(negedge clock);
    endtask

    task automatic do_read(input logic [7:0] d, output int lat, output int deq_cycle);
        rd_req_in = 1'b1;
        exp_rd.push_back(d);
        lat = -1;
        deq_cycle = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i == 1) rd_req_in = 1'b0;
            if (q_deq_out && deq_cycle < 0) deq_cycle = i;
            if (rd_valid_out) begin
                lat = i;
                break;
            end
        end
        rd_req_in = 1'b0;
        if (lat < 0) begin
            checkOutput("rd_valid_timeout", 32'(lat), 32'd4);
        end
        @(negedge clock);
    endtask

    task automatic wait_reads_done(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_rd.size() > 0; i++) begin
            @(negedge clock);
        end
        checkOutput("rd_drain", 32'(exp_rd.size()), 32'd0);
    endtask

    task automatic applyStimulus();
        int         lat;
        int         dq;
        int         rd_cycle;
        int         ack_cycle;
        int         wr_idx;
        int         rd_issued;
        int         gcount;
        logic [4:0] glog;
        logic       saw;
        logic [7:0] d;

        repeat (2) @(negedge clock);
        checkOutput("rst_wr_ack", 32'(wr_ack_out), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid_out), 32'd0);
        checkOutput("rst_q_enq", 32'(q_enq_out), 32'd0);
        checkOutput("rst_q_deq", 32'(q_deq_out), 32'd0);
        checkOutput("rst_q_data", 32'(q_data_out), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data_out), 32'd0);
        checkOutput("rst_empty", 32'(empty_out), 32'd1);
        checkOutput("rst_full", 32'(full_out), 32'd0);
        reset = 1'b1;

        $display("[TB] write to empty queue");
        do_write(8'hA5, lat);
        checkOutput("wr_latency", 32'(lat), 32'd1);
        checkOutput("empty_after_write", 32'(empty_out), 32'd0);

        $display("[TB] three writes then reads in order");
        do_write(8'h11, lat);
        do_write(8'h22, lat);
        do_write(8'h33, lat);
        do_read(8'hA5, lat, dq);
        checkOutput("rd_latency", 32'(lat), 32'd4);
        checkOutput("deq_cycle", 32'(dq), 32'd2);
        do_read(8'h11, lat, dq);
        do_read(8'h22, lat, dq);
        do_read(8'h33, lat, dq);
        repeat (3) @(negedge clock);
        checkOutput("rd_data_hold", 32'(rd_data_out), 32'h33);
        checkOutput("empty_after_drain", 32'(empty_out), 32'd1);

        $display("[TB] empty stall");
        rd_req_in = 1'b1;
        exp_rd.push_back(8'h5A);
        @(negedge clock);
        rd_req_in = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clock);
            saw |= q_deq_out;
        end
        checkOutput("deq_while_empty", 32'(saw), 32'd0);
        checkOutput("empty_stall", 32'(empty_out), 32'd1);
        do_write(8'h5A, lat);
        checkOutput("wr_latency_rd_pending", 32'(lat), 32'd1);
        wait_reads_done(10);

        $display("[TB] full stall");
        d = 8'h80;
        for (int i = 0; i < 8; i++) begin
            do_write(d, lat);
            d = d + 8'h01;
        end
        checkOutput("full_at_depth", 32'(full_out), 32'd1);
        wr_data_in  = 8'hFF;
        wr_valid_in = 1'b1;
        exp_wr.push_back(8'hFF);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clock);
            saw |= wr_ack_out;
        end
        checkOutput("ack_while_full", 32'(saw), 32'd0);
        rd_req_in = 1'b1;
        exp_rd.push_back(8'h80);
        rd_cycle  = -1;
        ack_cycle = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i == 1) rd_req_in = 1'b0;
            if (rd_valid_out && rd_cycle < 0) rd_cycle = i;
            if (wr_ack_out) begin
                ack_cycle = i;
                break;
            end
        end
        wr_valid_in = 1'b0;
        checkOutput("read_then_stalled_ack", 32'(rd_cycle > 0 && ack_cycle > rd_cycle), 32'd1);
        @(negedge clock);
        checkOutput("full_refilled", 32'(full_out), 32'd1);
        d = 8'h81;
        for (int i = 0; i < 4; i++) begin
            do_read(d, lat, dq);
            d = d + 8'h01;
        end

        $display("[TB] contention after reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset       = 1'b1;
        wr_data_in  = 8'hC1;
        wr_valid_in = 1'b1;
        exp_wr.push_back(8'hC1);
        rd_req_in = 1'b1;
        exp_rd.push_back(8'h85);
        wr_idx    = 1;
        rd_issued = 1;
        glog      = '0;
        gcount    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            rd_req_in = 1'b0;
            if (q_enq_out) begin
                glog = {glog[3:0], 1'b1};
                gcount++;
            end
            if (q_deq_out) begin
                glog = {glog[3:0], 1'b0};
                gcount++;
            end
            if (wr_ack_out) begin
                if (wr_idx < 3) begin
                    wr_data_in = wr_data_in + 8'h01;
                    exp_wr.push_back(wr_data_in);
                    wr_idx++;
                end else begin
                    wr_valid_in = 1'b0;
                end
            end
            if (rd_valid_out && rd_issued < 2) begin
                rd_req_in = 1'b1;
                exp_rd.push_back(8'h86);
                rd_issued++;
            end
        end
        rd_req_in   = 1'b0;
        wr_valid_in = 1'b0;
        checkOutput("grant_count", 32'(gcount), 32'd5);
        checkOutput("grant_order", 32'(glog), 32'b10101);
        wait_reads_done(10);
        repeat (2) @(negedge clock);

        $display("[TB] reset during DEQ");
        rd_req_in = 1'b1;
        @(negedge clock);
        rd_req_in = 1'b0;
        @(negedge clock);
        checkOutput("deq_before_reset", 32'(q_deq_out), 32'd1);
        #5 reset = 1'b0;
        #1;
        checkOutput("abort_q_deq", 32'(q_deq_out), 32'd0);
        checkOutput("abort_q_enq", 32'(q_enq_out), 32'd0);
        checkOutput("abort_wr_ack", 32'(wr_ack_out), 32'd0);
        checkOutput("abort_rd_valid", 32'(rd_valid_out), 32'd0);
        checkOutput("abort_rd_data", 32'(rd_data_out), 32'd0);
        checkOutput("abort_q_data", 32'(q_data_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clock);
            saw |= q_deq_out | q_enq_out | rd_valid_out | wr_ack_out;
        end
        checkOutput("strobes_after_reset", 32'(saw), 32'd0);
        do_read(8'h87, lat, dq);
        checkOutput("rd_latency_after_reset", 32'(lat), 32'd4);
        checkOutput("wr_drain", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        fork
            monitorLoop();
        join_none
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
